// File: rtl/dht11_poller.sv
// dht11_poller: periodic acquisition sequencer for a DHT11 sensor core.
//
// Pulses the sensor core's clear and start, waits (bounded) for a done or
// error edge, retries after a gap on error or timeout, latches good samples
// and flags an over-temperature condition.  After each acquisition (good or
// exhausted) it idles in HOLD for PERIOD_CYCLES before the next one.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enable                  level, run periodic acquisitions
//   i_temp_limit              over-temperature threshold (integer degrees C)
//   i_sensor_done/_err        sensor-core level flags
//   i_sensor_temp/_hum        sensor-core data, [15:8] integer, [7:0] decimal
//   o_sensor_clr/_start       one-cycle strobes to the sensor core
//   o_temp_int/_dec,
//   o_hum_int/_dec            last good sample
//   o_sample_valid            a good sample has been latched since reset
//   o_new_sample              one-cycle pulse per latched sample
//   o_over_temp               last good temp_int > i_temp_limit (unsigned)
//   o_fail                    one-cycle pulse when all retries are exhausted
//   o_fail_count              exhausted acquisitions, saturating at 255
//   o_busy                    high in every state except IDLE and HOLD
module dht11_poller #(
  parameter int unsigned PERIOD_CYCLES  = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES     = 5000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_temp_limit,
  input  logic        i_sensor_done,
  input  logic        i_sensor_err,
  input  logic [15:0] i_sensor_temp,
  input  logic [15:0] i_sensor_hum,
  output logic        o_sensor_clr,
  output logic        o_sensor_start,
  output logic [7:0]  o_temp_int,
  output logic [7:0]  o_temp_dec,
  output logic [7:0]  o_hum_int,
  output logic [7:0]  o_hum_dec,
  output logic        o_sample_valid,
  output logic        o_new_sample,
  output logic        o_over_temp,
  output logic        o_fail,
  output logic [7:0]  o_fail_count,
  output logic        o_busy
);

  localparam int unsigned MaxAB     = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES
                                                                        : TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > GAP_CYCLES) ? MaxAB : GAP_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned RetryW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CntW-1:0]   PeriodLast  = CntW'(PERIOD_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]   GapLast     = CntW'(GAP_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);
  localparam logic [CntW-1:0]   CntOne      = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StClear, StStart, StWait, StLatch, StGap, StFail, StHold
  } state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;        // shared by WAIT, GAP and HOLD; cleared on entry
  logic [RetryW-1:0] r_retry_cnt;
  logic              r_done_q;
  logic              r_err_q;
  logic              r_sensor_clr;
  logic              r_sensor_start;
  logic [7:0]        r_temp_int;
  logic [7:0]        r_temp_dec;
  logic [7:0]        r_hum_int;
  logic [7:0]        r_hum_dec;
  logic              r_sample_valid;
  logic              r_new_sample;
  logic              r_over_temp;
  logic              r_fail;
  logic [7:0]        r_fail_count;
  logic              r_busy;

  logic w_done_rise;
  logic w_err_rise;

  assign w_done_rise = i_sensor_done & ~r_done_q;
  assign w_err_rise  = i_sensor_err & ~r_err_q;

  // Strobe outputs are set on the transition into their state so each one is
  // high for exactly the cycle the FSM spends in that state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_retry_cnt    <= '0;
      r_done_q       <= 1'b0;
      r_err_q        <= 1'b0;
      r_sensor_clr   <= 1'b0;
      r_sensor_start <= 1'b0;
      r_temp_int     <= 8'd0;
      r_temp_dec     <= 8'd0;
      r_hum_int      <= 8'd0;
      r_hum_dec      <= 8'd0;
      r_sample_valid <= 1'b0;
      r_new_sample   <= 1'b0;
      r_over_temp    <= 1'b0;
      r_fail         <= 1'b0;
      r_fail_count   <= 8'd0;
      r_busy         <= 1'b0;
    end else begin
      r_sensor_clr   <= 1'b0;
      r_sensor_start <= 1'b0;
      r_new_sample   <= 1'b0;
      r_fail         <= 1'b0;
      r_done_q       <= i_sensor_done;
      r_err_q        <= i_sensor_err;

      case (r_state)
        StIdle: begin
          if (i_enable) begin
            r_state      <= StClear;
            r_sensor_clr <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        StClear: begin
          // Forget stale flags so a level left over from the last attempt
          // cannot masquerade as a fresh edge.
          r_done_q       <= 1'b0;
          r_err_q        <= 1'b0;
          r_state        <= StStart;
          r_sensor_start <= 1'b1;
        end

        StStart: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end

        StWait: begin
          if (w_done_rise) begin
            // Done wins over a simultaneous error edge or timeout.
            r_temp_int     <= i_sensor_temp[15:8];
            r_temp_dec     <= i_sensor_temp[7:0];
            r_hum_int      <= i_sensor_hum[15:8];
            r_hum_dec      <= i_sensor_hum[7:0];
            r_over_temp    <= (i_sensor_temp[15:8] > i_temp_limit);
            r_sample_valid <= 1'b1;
            r_new_sample   <= 1'b1;
            r_state        <= StLatch;
          end else if (w_err_rise || (r_cnt == TimeoutLast)) begin
            if (r_retry_cnt < RetryMax) begin
              r_retry_cnt <= r_retry_cnt + RetryW'(1);
              r_cnt       <= '0;
              r_state     <= StGap;
            end else begin
              r_retry_cnt  <= '0;
              r_fail       <= 1'b1;
              r_fail_count <= (r_fail_count == 8'hFF) ? 8'hFF : r_fail_count + 8'd1;
              r_state      <= StFail;
            end
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        StLatch: begin
          r_retry_cnt <= '0;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_state     <= StHold;
        end

        StGap: begin
          if (r_cnt == GapLast) begin
            r_sensor_clr <= 1'b1;
            r_state      <= StClear;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        StFail: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= StHold;
        end

        StHold: begin
          // Enable is only sampled here and in IDLE.
          if (r_cnt == PeriodLast) begin
            if (i_enable) begin
              r_sensor_clr <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= StClear;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_sensor_clr   = r_sensor_clr;
  assign o_sensor_start = r_sensor_start;
  assign o_temp_int     = r_temp_int;
  assign o_temp_dec     = r_temp_dec;
  assign o_hum_int      = r_hum_int;
  assign o_hum_dec      = r_hum_dec;
  assign o_sample_valid = r_sample_valid;
  assign o_new_sample   = r_new_sample;
  assign o_over_temp    = r_over_temp;
  assign o_fail         = r_fail;
  assign o_fail_count   = r_fail_count;
  assign o_busy         = r_busy;

endmodule

// File: doc/dht11_poller.md
DHT11_POLLER -- requirements
Module: dht11_poller

Interface
REQ-001 Parameter PERIOD_CYCLES, default 100000000, clock cycles spent in HOLD between acquisitions (2 s at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 250000, maximum cycles in WAIT per attempt (5 ms).
REQ-003 Parameter GAP_CYCLES, default 5000000, cycles in GAP before a retry (100 ms).
REQ-004 Parameter MAX_RETRY, default 2, retries allowed after a failed first attempt.
REQ-005 clock  in  1  system clock, single clock domain.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  level; 1 = run periodic acquisitions.
REQ-008 temp_limit  in  8  over-temperature threshold, integer degrees C.
REQ-009 sensor_done  in  1  sensor-core level flag, measurement complete.
REQ-010 sensor_err  in  1  sensor-core level flag, measurement failed.
REQ-011 sensor_temp  in  16  sensor-core temperature, [15:8] integer part, [7:0] decimal part.
REQ-012 sensor_hum  in  16  sensor-core humidity, [15:8] integer part, [7:0] decimal part.
REQ-013 sensor_clr  out  1  one-cycle active-high clear to the sensor core.
REQ-014 sensor_start  out  1  one-cycle start pulse to the sensor core.
REQ-015 temp_int, temp_dec, hum_int, hum_dec  out  8 each  last good sample.
REQ-016 sample_valid  out  1  high once any good sample has been latched.
REQ-017 new_sample  out  1  one-cycle pulse per latched sample.
REQ-018 over_temp  out  1  temp_int of the last good sample > temp_limit.
REQ-019 fail  out  1  one-cycle pulse when all retries are exhausted.
REQ-020 fail_count  out  8  count of exhausted acquisitions, saturating at 255.
REQ-021 busy  out  1  high in every state except IDLE and HOLD.

Function
REQ-022 States SHALL be IDLE, CLEAR, START, WAIT, LATCH, GAP, FAIL and HOLD.
REQ-023 IDLE: enable=1 -> CLEAR on the next cycle; otherwise stay.
REQ-024 CLEAR: sensor_clr=1 for exactly one cycle -> START.
REQ-025 START: sensor_start=1 for exactly one cycle, wait counter cleared -> WAIT.
REQ-026 WAIT: a rising edge on sensor_done -> LATCH; a rising edge on sensor_err, or wait counter = TIMEOUT_CYCLES-1 -> retry decision; otherwise increment.
REQ-027 Rising edges SHALL be detected against a one-cycle registered copy, cleared in CLEAR.
REQ-028 Simultaneous done and err edges: done wins.
REQ-029 Retry decision: retry_cnt < MAX_RETRY -> retry_cnt+1, GAP; else -> FAIL.
REQ-030 GAP: count GAP_CYCLES cycles, then -> CLEAR.
REQ-031 LATCH: register the four bytes, set sample_valid, pulse new_sample, update over_temp, clear retry_cnt -> HOLD; total latency from the done edge to new_sample is 1 cycle.
REQ-032 FAIL: pulse fail, fail_count+1 saturating, retry_cnt cleared -> HOLD; sample outputs and sample_valid unchanged.
REQ-033 HOLD: count PERIOD_CYCLES cycles, then -> CLEAR if enable=1, else -> IDLE.
REQ-034 enable deassertion SHALL take effect only on HOLD exit or in IDLE; an acquisition in progress completes.
REQ-035 The comparison for over_temp SHALL be unsigned and strict (equal value -> 0).
REQ-036 Counter widths SHALL be $clog2 of the largest parameter; counters never wrap.

Reset
REQ-037 With reset=0: state IDLE; all counters 0; all outputs 0.
REQ-038 Reset asserted mid-acquisition SHALL abort immediately, with no fail pulse and no fail_count change.

Verification (PERIOD_CYCLES=50, TIMEOUT_CYCLES=20, GAP_CYCLES=10, MAX_RETRY=2)
REQ-039 enable=1, done edge 5 cycles after start, temp=0x1A05, hum=0x3C00, limit=30 -> new_sample once; temp_int=26, temp_dec=5, hum_int=60, over_temp=0, sample_valid=1.
REQ-040 sensor_err edge on the first attempt, done on the second -> exactly 2 sensor_start pulses 1 GAP apart, no fail pulse, sample latched.
REQ-041 No response at all -> 3 attempts each 20 cycles, 1 fail pulse, fail_count=1, prior sample retained, then HOLD for 50 cycles.
REQ-042 Done and err edges in the same cycle -> LATCH, no retry.
REQ-043 temp_int=31, limit=30 -> over_temp=1; temp_int=30 -> 0; drop enable during WAIT -> acquisition completes, then IDLE after HOLD.
REQ-044 Reset pulsed in WAIT -> all outputs 0 the same cycle; fail_count forced to 255 then one more failure -> stays 255.
